// File: rtl/uop_onehot_strobe_dec.sv
// uop_onehot_strobe_dec: registered one-hot strobe of in_len+1 cycles; define UOP_DEC_ERR_EN to reject out-of-range selects with an err pulse
module uop_onehot_strobe_dec #(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [LEN_W-1:0]   in_len,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic               out_active,
  output logic               err
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [LEN_W-1:0] cnt;
  logic [NUM_OUT-1:0] onehot_reg, dec;
  logic accept, last, start;
  // select decode; codes at or above NUM_OUT decode to all zeros
  always_comb begin
    dec = '0;
    for (int i = 0; i < NUM_OUT; i++) dec[i] = in_sel == SEL_W'(i);
  end
  assign last       = cnt == '0;
  assign in_ready   = rst_n && !flush && (state == IDLE || last);
  assign accept     = in_valid && in_ready;
  assign out_onehot = onehot_reg & {NUM_OUT{enable}};
  assign out_active = state == ACTIVE;
`ifdef UOP_DEC_ERR_EN
  logic in_range;
  assign in_range = |dec;
  assign start    = accept && in_range;
  // one-cycle error pulse for an accepted out-of-range select
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else err <= accept && !in_range;
`else
  assign start = accept;
  assign err   = 1'b0;
`endif
  // strobe sequencer: load on start, count down, drop to idle at zero or on flush
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      onehot_reg <= '0;
    end else if (flush) begin
      state      <= IDLE;
      cnt        <= '0;
      onehot_reg <= '0;
    end else if (start) begin
      state      <= ACTIVE;
      cnt        <= in_len;
      onehot_reg <= dec;
    end else if (state == ACTIVE && !last) begin
      cnt <= cnt - 1'b1;
    end else begin
      state      <= IDLE;
      onehot_reg <= '0;
    end
endmodule

// File: tb/tb_uop_onehot_strobe_dec.sv
// tb_uop_onehot_strobe_dec: directed and random checks of two decoder instances (NUM_OUT=4 and NUM_OUT=3) against a cycle-count model
module tb_uop_onehot_strobe_dec;
`ifdef UOP_DEC_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0, rst_n, enable, flush, in_valid;
  logic [1:0] in_sel;
  logic [3:0] in_len;
  logic rdy4, rdy3, act4, act3, err4, err3;
  logic [3:0] oh4;
  logic [2:0] oh3;
  int n_chk = 0, n_fail = 0;
  bit m_act [2] = '{0, 0};
  bit m_err [2] = '{0, 0};
  int m_rem [2] = '{0, 0};
  int m_sel [2] = '{0, 0};

  always #5 clk = ~clk;

  uop_onehot_strobe_dec dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy4), .in_sel(in_sel), .in_len(in_len), .out_onehot(oh4),
    .out_active(act4), .err(err4));

  uop_onehot_strobe_dec #(.SEL_W(2), .NUM_OUT(3), .LEN_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .in_valid(in_valid),
    .in_ready(rdy3), .in_sel(in_sel), .in_len(in_len), .out_onehot(oh3),
    .out_active(act3), .err(err3));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // model: m_rem counts strobe cycles still to show, including the current one
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0; m_err[k] = 0; m_rem[k] = 0; m_sel[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int n;
        bit acc, inr;
        n = k ? 3 : 4;
        acc = in_valid && !flush && (!m_act[k] || m_rem[k] == 1);
        inr = int'(in_sel) < n;
        m_err[k] = 0;
        if (flush) m_act[k] = 0;
        else if (acc && (inr || !ERR)) begin
          m_act[k] = 1; m_rem[k] = int'(in_len) + 1; m_sel[k] = int'(in_sel);
        end else if (acc) begin
          m_act[k] = 0; m_err[k] = 1;
        end else if (m_act[k]) begin
          m_rem[k]--;
          if (m_rem[k] == 0) m_act[k] = 0;
        end
      end
    end
  end

  // every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    int n;
    logic [3:0] eoh, aoh;
    logic erdy;
    for (int k = 0; k < 2; k++) begin
      n = k ? 3 : 4;
      eoh = (m_act[k] && enable && m_sel[k] < n) ? 4'(1 << m_sel[k]) : 4'd0;
      erdy = rst_n && !flush && (!m_act[k] || m_rem[k] == 1);
      aoh = k ? {1'b0, oh3} : oh4;
      chk(k ? "model_oh3" : "model_oh4", aoh, eoh);
      chk(k ? "model_rdy3" : "model_rdy4", k ? rdy3 : rdy4, erdy);
      chk(k ? "model_act3" : "model_act4", k ? act3 : act4, m_act[k]);
      chk(k ? "model_err3" : "model_err4", k ? err3 : err4, m_err[k]);
    end
    chk("onehot0", $onehot0(oh4) && $onehot0(oh3), 1);
  end

  initial begin
    int cnt;
    rst_n = 0; enable = 1; flush = 0; in_valid = 0; in_sel = 0; in_len = 0;
    #2;
    chk("rst_oh", oh4, 0); chk("rst_act", act4, 0); chk("rst_rdy", rdy4, 0); chk("rst_err", err3, 0);
    #10 rst_n = 1;
    #1 chk("rel_rdy", rdy4, 1);
    step; in_valid = 1; in_sel = 2; in_len = 2;
    step; in_valid = 0;
    @(negedge clk); chk("basic_t1_oh", oh4, 4'b0100); chk("basic_t1_rdy", rdy4, 0);
    step; @(negedge clk); chk("basic_t2_oh", oh4, 4'b0100); chk("basic_t2_rdy", rdy4, 0);
    step; @(negedge clk); chk("basic_t3_oh", oh4, 4'b0100); chk("basic_t3_rdy", rdy4, 1);
    step; @(negedge clk); chk("basic_t4_oh", oh4, 4'b0000); chk("basic_t4_act", act4, 0);
    step; in_valid = 1; in_sel = 1; in_len = 0;
    step; in_sel = 3; in_len = 1;
    @(negedge clk); chk("b2b_0_oh", oh4, 4'b0010); chk("b2b_0_rdy", rdy4, 1);
    step; in_valid = 0;
    @(negedge clk); chk("b2b_1_oh", oh4, 4'b1000);
    step; @(negedge clk); chk("b2b_2_oh", oh4, 4'b1000);
    step; @(negedge clk); chk("b2b_3_oh", oh4, 4'b0000);
    step; in_valid = 1; in_sel = 0; in_len = 7;
    step; in_valid = 0;
    step; flush = 1; in_valid = 1; in_sel = 1; in_len = 0;
    @(negedge clk); chk("flush_rdy", rdy4, 0); chk("flush_oh", oh4, 4'b0001);
    step; flush = 0; in_valid = 0;
    @(negedge clk); chk("flush_act", act4, 0); chk("flush_oh2", oh4, 0);
    step; in_valid = 1; in_sel = 3; in_len = 5;
    step; in_valid = 0;
    @(negedge clk); chk("en_c1_oh", oh4, 4'b1000);
    step; enable = 0;
    @(negedge clk); chk("en_c2_oh", oh4, 0); chk("en_c2_act", act4, 1);
    step; @(negedge clk); chk("en_c3_oh", oh4, 0);
    step; enable = 1;
    @(negedge clk); chk("en_c4_oh", oh4, 4'b1000);
    step; step; @(negedge clk); chk("en_c6_oh", oh4, 4'b1000); chk("en_c6_act", act4, 1);
    step; @(negedge clk); chk("en_c7_act", act4, 0);
    step; in_valid = 1; in_sel = 3; in_len = 2;
    step; in_valid = 0;
    @(negedge clk);
`ifdef UOP_DEC_ERR_EN
    chk("rng_err", err3, 1); chk("rng_act", act3, 0);
    step; @(negedge clk); chk("rng_err2", err3, 0); chk("rng_act2", act3, 0);
`else
    chk("rng_act", act3, 1); chk("rng_oh", oh3, 0); chk("rng_err", err3, 0);
    step; @(negedge clk); chk("rng_act2", act3, 1);
`endif
    step; step; @(negedge clk); chk("rng_end", act3, 0);
    step; in_valid = 1; in_sel = 1; in_len = 4'hF;
    step; in_valid = 0;
    cnt = 0;
    repeat (24) begin
      @(negedge clk);
      if (act4) cnt++;
      step;
    end
    chk("len16", cnt, 16);
    step; in_valid = 1; in_sel = 0; in_len = 5;
    step; in_valid = 0;
    step; #2 rst_n = 0;
    #1 chk("rms_oh", oh4, 0); chk("rms_act", act4, 0); chk("rms_rdy", rdy4, 0);
    #3 rst_n = 1;
    step; chk("rms_rdy1", rdy4, 1);
    repeat (3000) begin
      step;
      in_valid = 1'($urandom);
      in_sel = 2'($urandom);
      in_len = ($urandom % 8 == 0) ? 4'hF : 4'($urandom_range(0, 3));
      flush = ($urandom % 16) == 0;
      enable = ($urandom % 8) != 0;
    end
    step; in_valid = 0; flush = 0; enable = 1;
    step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uop_onehot_strobe_dec.md
Name: uop_onehot_strobe_dec

Overview:
- Parametrised, registered successor to the single-bit uCode-type decoder in the CtrlPIM control path.
- Accepts a SEL_W-bit operation-select code plus a strobe length from the control-memory sequencer over a valid/ready handshake.
- Drives a one-hot NUM_OUT-wide operation strobe for a programmable number of cycles, then returns the output to zero.
- Supports back-to-back issue, synchronous flush and a global enable gate.

Parameters:
- SEL_W, 2, select code width.
- NUM_OUT, 4, number of one-hot outputs; must satisfy 2 <= NUM_OUT <= 2**SEL_W.
- LEN_W, 4, strobe-length field width; strobe lasts in_len+1 cycles (1..2**LEN_W).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  global gate; when low, out_onehot reads 0 but sequencing continues.
- flush  in  1  synchronous abort of the current strobe.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_sel  in  SEL_W  operation select code.
- in_len  in  LEN_W  strobe length minus one.
- out_onehot  out  NUM_OUT  one-hot operation strobe.
- out_active  out  1  a strobe is in progress (independent of enable).
- err  out  1  out-of-range pulse (UOP_DEC_ERR_EN only; tied 0 otherwise).

Behaviour:
- Reset (async assert, sync release): state=IDLE, cnt=0, onehot_reg=0. Outputs: out_onehot=0, out_active=0, err=0, in_ready=0 while rst_n low.
- States: IDLE and ACTIVE.
  - IDLE->ACTIVE on accept.
  - ACTIVE->ACTIVE on accept while cnt==0 (back-to-back issue).
  - ACTIVE->IDLE when cnt==0 with no accept.
  - Any state->IDLE on flush.
- Accept = in_valid && in_ready.
- in_ready = !flush && (state==IDLE || (state==ACTIVE && cnt==0)). Combinational from state and flush only, never from in_valid.
- On accept: onehot_reg <= (1 << in_sel) truncated to NUM_OUT bits; cnt <= in_len; state <= ACTIVE.
- Latency: strobe is visible the cycle after accept and holds exactly in_len+1 cycles.
- Back-to-back: a request accepted in the last strobe cycle starts in the next cycle with no zero gap. The output changes directly from the old one-hot value to the new one.
- In ACTIVE with cnt!=0: cnt decrements by 1 each cycle. cnt never wraps.
- out_onehot = onehot_reg & {NUM_OUT{enable}}, a combinational AND after the register.
- Deasserting enable mid-strobe does not extend the strobe; the elapsed cycles still count.
- out_active = (state==ACTIVE).
- Flush: the next cycle has state=IDLE and onehot_reg=0. in_ready is 0 during the flush cycle, so flush always wins over a simultaneous request.
- Out-of-range in_sel (>= NUM_OUT) without ERR_EN: the request is accepted and runs its full length with out_onehot=0.
- in_len=0 gives a 1-cycle strobe; in_len=all-ones gives a 2**LEN_W-cycle strobe.
- Invariant: out_onehot has at most one bit set in every cycle.

Optional Feature:
- Macro: UOP_DEC_ERR_EN.
- Defined: an out-of-range in_sel is still accepted (handshake completes) but starts no strobe.
  - State does not change (IDLE stays IDLE; an ACTIVE at cnt==0 ends normally).
  - err pulses high for exactly one cycle, the cycle after accept.
  - A flush in the same cycle as such a request suppresses both the accept and err.
- Undefined: err is constant 0 and out-of-range codes behave as described in Behaviour.

Test Plan:
- Reset mid-strobe: rst_n low during an in_len=5 strobe -> out_onehot=0, out_active=0 immediately (async); after release in_ready=1.
- Basic issue: in_sel=2, in_len=2 (defaults) -> out_onehot=4'b0100 for cycles t+1..t+3, 0 at t+4; in_ready=0 at t+1..t+2, 1 at t+3.
- Back-to-back: sel=1,len=0 then sel=3,len=1 held valid -> out_onehot 0010, 1000, 1000, 0000 with no gap.
- Flush and enable: flush at cycle 2 of an in_len=7 strobe with in_valid high -> the request is not accepted, IDLE and out_onehot=0 next cycle. enable low for 2 mid-strobe cycles -> output 0 for those cycles and the total strobe length is unchanged.
- Range with NUM_OUT=3, SEL_W=2, in_sel=3:
  - ERR_EN defined: err=1 for one cycle, out_active stays 0.
  - ERR_EN undefined: out_active=1 for in_len+1 cycles with out_onehot=0.
- Boundary: in_len=4'hF -> exactly 16 strobe cycles. A random soak checks the one-hot-or-zero invariant every cycle.
